// File: rtl/decoder_seq.sv
// ---------------------------------------------------------------------------
// decoder_seq
//
// This block is a sequenced N-to-2^N line decoder with valid/ready handshakes
// on its input and output sides.
//
// A request is one sel/mode pair. The block accepts it when in_valid and
// in_ready are both high at a rising edge.
//   mode = 0 : the block presents the single line onehot(sel) until the
//              consumer takes it.
//   mode = 1 : the block presents all 2^N lines in turn, starting at sel and
//              wrapping modulo 2^N. Each line is one output beat.
// done pulses for one cycle after the final output handshake of a request.
//
// Parameters
//   N       : select width (1..6); the output width is 2^N
//   ACT_LOW : 0 -> the active line is 1; 1 -> the active line is 0, others 1
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset; overrides every other input
//   en        in   global enable; when low, all state freezes and the
//                  handshake outputs are forced idle
//   in_valid  in   a request is present on sel/mode
//   in_ready  out  the block can accept a request (IDLE and enabled)
//   sel       in   decode index (mode 0) or sweep start index (mode 1)
//   mode      in   0 = single decode, 1 = sweep of all lines
//   out_valid out  y carries a valid decoded line
//   out_ready in   the consumer accepts the current y
//   y         out  one-hot (or one-cold) decoded line; inactive when not valid
//   busy      out  a transaction is in progress
//   done      out  one-cycle pulse after the final output handshake
// ---------------------------------------------------------------------------
module decoder_seq #(
  parameter int N       = 3,
  parameter int ACT_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         sel,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [(1 << N)-1:0]  y,
  output logic                 busy,
  output logic                 done
);

  localparam int W = 1 << N;

  // This is the beat counter value on the last beat of a sweep (2^N - 1).
  localparam logic [N:0] LAST_BEAT = {1'b0, {N{1'b1}}};

  // This is the output level when no line is being driven.
  localparam logic [W-1:0] INACTIVE = (ACT_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SWEEP
  } state_t;

  state_t       state;
  logic [N-1:0] idx;
  logic [N:0]   cnt;
  logic [W-1:0] hot_q;
  logic         done_q;

  // The controller is a single registered FSM.
  // It updates only while en is high, so deasserting en freezes the state,
  // the index, the beat counter and the pending done flag exactly as they
  // are. The registered active-high decode (hot_q) is updated together with
  // idx. This keeps y a flop output rather than a decoder hanging off idx.
  // done_q is set only on the edge that completes a transaction. It is
  // cleared on the next enabled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      hot_q  <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= mode ? SWEEP : HOLD;
            idx   <= sel;
            cnt   <= '0;
            hot_q <= W'(1) << sel;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        SWEEP: begin
          if (out_ready) begin
            if (cnt == LAST_BEAT) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              idx   <= idx + N'(1);
              cnt   <= cnt + (N+1)'(1);
              hot_q <= W'(1) << (idx + N'(1));
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // These outputs are derived from registered state and gated by en.
  // While the block is disabled it offers no handshake on either side, shows
  // an inactive y and suppresses done. busy still reflects the frozen state,
  // because the transaction is paused, not finished.
  always_comb begin
    in_ready  = (state == IDLE) && en;
    out_valid = (state != IDLE) && en;
    busy      = (state != IDLE);
    done      = done_q && en;
    y         = INACTIVE;
    if (out_valid) begin
      y = (ACT_LOW != 0) ? ~hot_q : hot_q;
    end
  end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter N, default 3, select width; legal range 1..6; output width is 2^N.
REQ-002 Parameter ACT_LOW, default 0: 0 means active output bit is 1; 1 means active output bit is 0 and all other bits are 1.
REQ-003 clk  input  1  single clock; every register updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  global enable; 0 freezes the block.
REQ-006 in_valid  input  1  request present on sel/mode.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 sel  input  N  decode index (mode 0) or sweep start index (mode 1).
REQ-009 mode  input  1  0 = single decode; 1 = sweep of all 2^N lines.
REQ-010 out_valid  output  1  y carries a valid decoded line.
REQ-011 out_ready  input  1  consumer accepts the current y.
REQ-012 y  output  2^N  registered one-hot (or one-cold) decode.
REQ-013 busy  output  1  transaction in progress (state not IDLE).
REQ-014 done  output  1  one-cycle pulse on the final output handshake of a transaction.

Function
REQ-015 States SHALL be IDLE, HOLD (mode 0) and SWEEP (mode 1); encoding is free.
REQ-016 in_ready SHALL be 1 only when state=IDLE and en=1.
REQ-017 An accept is in_valid & in_ready at a clock edge; sel and mode SHALL be captured only on an accept.
REQ-018 Accept with mode=0: next state HOLD, idx <= sel, out_valid=1 starting the following cycle; latency is exactly 1 clock.
REQ-019 Accept with mode=1: next state SWEEP, idx <= sel, beat counter <= 0, out_valid=1 starting the following cycle.
REQ-020 An output handshake is out_valid & out_ready at a clock edge; y and out_valid SHALL hold stable until the handshake occurs.
REQ-021 HOLD: on the handshake, done=1 for that cycle's successor and state returns to IDLE; otherwise HOLD persists.
REQ-022 SWEEP: each handshake advances idx by 1 modulo 2^N (2^N-1 wraps to 0) and increments the beat counter (N+1 bits).
REQ-023 SWEEP SHALL emit exactly 2^N beats; the handshake on beat 2^N (counter = 2^N-1) pulses done and returns to IDLE.
REQ-024 When out_valid=1, y SHALL equal onehot(idx); when ACT_LOW=1, y is the bitwise inverse.
REQ-025 When out_valid=0, y SHALL be all inactive: all 0 (ACT_LOW=0) or all 1 (ACT_LOW=1).
REQ-026 en=0: all registers hold; in_ready=0 and out_valid=0 (y inactive); no handshakes or done pulses occur; operation resumes unchanged when en returns to 1.
REQ-027 busy SHALL be 1 in HOLD and SWEEP, 0 in IDLE.
REQ-028 done SHALL be registered and high for exactly one cycle, at most once per transaction.
REQ-029 in_valid while busy SHALL be ignored; no request is queued.
REQ-030 N=1 is legal: the sweep is 2 beats and y is 2 bits wide.

Reset
REQ-031 On rst=1 at a clock edge: state IDLE, idx=0, counter=0, out_valid=0, done=0, busy=0, y inactive; in_ready=en from the following cycle.
REQ-032 rst SHALL take priority over en, in_valid and out_ready.
REQ-033 rst during HOLD or SWEEP SHALL abort the transaction without a done pulse.

Verification
REQ-034 N=3, ACT_LOW=0: accept mode=0, sel=5, out_ready=1 -> next cycle y=8'b0010_0000, out_valid=1; following cycle done=1, busy=0.
REQ-035 N=3: accept mode=1, sel=6, out_ready held 1 -> y sequence is lines 6,7,0,1,2,3,4,5 (8 beats); done pulses once after beat 8.
REQ-036 Sweep with out_ready toggling 1,0,1,0 -> y stable while out_ready=0; idx advances only on handshakes; still exactly 8 beats.
REQ-037 ACT_LOW=1, mode=0, sel=0 -> y=8'b1111_1110 while valid and 8'hFF when idle.
REQ-038 en=0 for 3 cycles during a sweep at idx=2 -> out_valid=0 and y inactive throughout; sweep resumes at idx=2 with no beat lost.
REQ-039 rst=1 at beat 4 of a sweep -> next cycle IDLE, out_valid=0, no done; a new request is accepted normally.
